vga2tmds_encoder: RTL and testbench



---
 rtl/vga2tmds_pkg.sv | 37 +++
 rtl/tmds_channel_enc.sv | 102 ++++++++++
 rtl/vga2tmds_encoder.sv | 143 ++++++++++++++
 tb/tb_vga2tmds_encoder.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga2tmds_pkg.sv
// Shared constants and helpers for the VGA-to-TMDS encoder.
// Holds the four TMDS control-period words, the word shown in and straight
// after reset, the running-disparity counter width, and two small helpers:
// control-word lookup and an 8-bit population count.
package vga2tmds_pkg;

  localparam logic [9:0] CTRL_CODE_00 = 10'h354;
  localparam logic [9:0] CTRL_CODE_01 = 10'h0AB;
  localparam logic [9:0] CTRL_CODE_10 = 10'h154;
  localparam logic [9:0] CTRL_CODE_11 = 10'h2AB;
  localparam logic [9:0] RESET_WORD   = 10'h354;
  localparam int         CNT_W        = 5;

  // Map {C1,C0} onto the TMDS control-period symbol.
  function automatic logic [9:0] ctrl_word(input logic [1:0] c);
    logic [9:0] w;
    case (c)
      2'b00:   w = CTRL_CODE_00;
      2'b01:   w = CTRL_CODE_01;
      2'b10:   w = CTRL_CODE_10;
      2'b11:   w = CTRL_CODE_11;
      default: w = RESET_WORD;
    endcase
    return w;
  endfunction

  // Number of ones in a byte (0..8).
  function automatic logic [3:0] ones8(input logic [7:0] d);
    logic [3:0] n;
    n = 4'd0;
    for (int i = 0; i < 8; i++) begin
      n = n + {3'b000, d[i]};
    end
    return n;
  endfunction

endpackage

// File: rtl/tmds_channel_enc.sv
// One TMDS channel: stage 1 (transition minimisation, registered q_m plus
// delayed blank/ctrl) and stage 2 (DC balancing against the channel's own
// running disparity, registered 10-bit symbol).
// Ports:
//   clk_pixel  pixel clock
//   reset      synchronous, active-high
//   data       8-bit pixel value
//   blank      1 = control period
//   ctrl       {C1,C0} sent during the control period
//   tmds       registered 10-bit symbol, bit 0 transmitted first
module tmds_channel_enc
  import vga2tmds_pkg::*;
(
  input  logic       clk_pixel,
  input  logic       reset,
  input  logic [7:0] data,
  input  logic       blank,
  input  logic [1:0] ctrl,
  output logic [9:0] tmds
);

  logic [3:0]              n1_data_s;
  logic                    use_xnor_s;
  logic [8:0]              q_m_s;
  logic [8:0]              q_m_r;
  logic                    blank_r;
  logic [1:0]              ctrl_r;
  logic [3:0]              n1_q_s;
  logic signed [5:0]       diff6_s;
  logic signed [CNT_W-1:0] diff_s;
  logic signed [CNT_W-1:0] cnt_r;
  logic signed [CNT_W-1:0] cnt_next_s;
  logic [9:0]              tmds_next_s;
  logic [9:0]              tmds_r;

  // Stage 1 combinational: choose XOR or XNOR chain to minimise transitions.
  always_comb begin
    n1_data_s  = ones8(data);
    use_xnor_s = (n1_data_s > 4'd4) || ((n1_data_s == 4'd4) && (data[0] == 1'b0));
    q_m_s      = 9'd0;
    q_m_s[0]   = data[0];
    for (int i = 1; i < 8; i++) begin
      if (use_xnor_s) begin
        q_m_s[i] = ~(q_m_s[i-1] ^ data[i]);
      end else begin
        q_m_s[i] = q_m_s[i-1] ^ data[i];
      end
    end
    q_m_s[8] = ~use_xnor_s;
  end

  // Stage 1 register; reset leaves the pipe in the blank, C=00 state.
  always_ff @(posedge clk_pixel) begin
    if (reset) begin
      q_m_r   <= 9'd0;
      blank_r <= 1'b1;
      ctrl_r  <= 2'b00;
    end else begin
      q_m_r   <= q_m_s;
      blank_r <= blank;
      ctrl_r  <= ctrl;
    end
  end

  // Stage 2 combinational: DC balance. diff_s is N1-N0 of q_m[7:0].
  always_comb begin
    n1_q_s      = ones8(q_m_r[7:0]);
    diff6_s     = $signed({1'b0, n1_q_s, 1'b0}) - 6'sd8;
    diff_s      = diff6_s[CNT_W-1:0];
    tmds_next_s = RESET_WORD;
    cnt_next_s  = cnt_r;
    if (blank_r) begin
      // Control period restarts disparity so the next active pixel starts at 0.
      tmds_next_s = ctrl_word(ctrl_r);
      cnt_next_s  = 5'sd0;
    end else if ((cnt_r == 5'sd0) || (diff_s == 5'sd0)) begin
      tmds_next_s = {~q_m_r[8], q_m_r[8], q_m_r[8] ? q_m_r[7:0] : ~q_m_r[7:0]};
      cnt_next_s  = q_m_r[8] ? (cnt_r + diff_s) : (cnt_r - diff_s);
    end else if (((cnt_r > 5'sd0) && (diff_s > 5'sd0)) ||
                 ((cnt_r < 5'sd0) && (diff_s < 5'sd0))) begin
      tmds_next_s = {1'b1, q_m_r[8], ~q_m_r[7:0]};
      cnt_next_s  = cnt_r - diff_s + (q_m_r[8] ? 5'sd2 : 5'sd0);
    end else begin
      tmds_next_s = {1'b0, q_m_r[8], q_m_r[7:0]};
      cnt_next_s  = cnt_r + diff_s - (q_m_r[8] ? 5'sd0 : 5'sd2);
    end
  end

  // Stage 2 register: output symbol and running disparity.
  always_ff @(posedge clk_pixel) begin
    if (reset) begin
      tmds_r <= RESET_WORD;
      cnt_r  <= 5'sd0;
    end else begin
      tmds_r <= tmds_next_s;
      cnt_r  <= cnt_next_s;
    end
  end

  assign tmds = tmds_r;

endmodule

// File: rtl/vga2tmds_encoder.sv
// VGA to DVI TMDS encoder, pixel-clock domain. Expands each colour to 8 bits,
// applies sync polarity, encodes three channels through a 2-stage core and
// adds C_out_reg extra output register stages (latency 2 + C_out_reg).
// Ports:
//   clk_pixel, reset               clock; synchronous active-high reset
//   in_red/in_green/in_blue        C_depth-bit colour
//   in_hsync/in_vsync/in_blank     sync and blank (blank=1: control period)
//   pattern_en                     only with VGA2TMDS_PATTERN_EN defined:
//                                  replaces colour with 8 vertical bars
//   out_red/out_green/out_blue     10-bit TMDS words, channels 2/1/0
// Optional build macro: VGA2TMDS_PATTERN_EN (adds pattern_en and bar generator).
module vga2tmds_encoder
  import vga2tmds_pkg::*;
#(
  parameter int C_depth     = 8,
  parameter int C_hsync_pol = 1,
  parameter int C_vsync_pol = 1,
  parameter int C_out_reg   = 1
) (
  input  logic               clk_pixel,
  input  logic               reset,
  input  logic [C_depth-1:0] in_red,
  input  logic [C_depth-1:0] in_green,
  input  logic [C_depth-1:0] in_blue,
  input  logic               in_hsync,
  input  logic               in_vsync,
  input  logic               in_blank,
`ifdef VGA2TMDS_PATTERN_EN
  input  logic               pattern_en,
`endif
  output logic [9:0]         out_red,
  output logic [9:0]         out_green,
  output logic [9:0]         out_blue
);

  logic [7:0]  red_exp_s, green_exp_s, blue_exp_s;
  logic [7:0]  red_s, green_s, blue_s;
  logic        c0_s, c1_s;
  logic [9:0]  red_core_s, green_core_s, blue_core_s;
  logic [29:0] core_s;

  // Replicate the value MSB-first until 8 bits are filled.
  for (genvar gi = 0; gi < 8; gi++) begin : g_expand
    assign red_exp_s[7-gi]   = in_red[C_depth-1-(gi % C_depth)];
    assign green_exp_s[7-gi] = in_green[C_depth-1-(gi % C_depth)];
    assign blue_exp_s[7-gi]  = in_blue[C_depth-1-(gi % C_depth)];
  end

`ifdef VGA2TMDS_PATTERN_EN
  logic [10:0] pix_cnt_r;
  logic [2:0]  bar_idx_s;

  // Active-pixel position within the line; held at its maximum rather than wrapping.
  always_ff @(posedge clk_pixel) begin
    if (reset) begin
      pix_cnt_r <= 11'd0;
    end else if (in_blank) begin
      pix_cnt_r <= 11'd0;
    end else if (pix_cnt_r != 11'h7FF) begin
      pix_cnt_r <= pix_cnt_r + 11'd1;
    end else begin
      pix_cnt_r <= pix_cnt_r;
    end
  end

  // 80-pixel bars; bar index bits select full-on R/G/B.
  always_comb begin
    if (pix_cnt_r >= 11'd560) begin
      bar_idx_s = 3'd7;
    end else begin
      bar_idx_s = 3'(pix_cnt_r / 11'd80);
    end
    if (pattern_en) begin
      red_s   = {8{bar_idx_s[2]}};
      green_s = {8{bar_idx_s[1]}};
      blue_s  = {8{bar_idx_s[0]}};
    end else begin
      red_s   = red_exp_s;
      green_s = green_exp_s;
      blue_s  = blue_exp_s;
    end
  end
`else
  assign red_s   = red_exp_s;
  assign green_s = green_exp_s;
  assign blue_s  = blue_exp_s;
`endif

  assign c0_s = (C_hsync_pol != 0) ? in_hsync : ~in_hsync;
  assign c1_s = (C_vsync_pol != 0) ? in_vsync : ~in_vsync;

  tmds_channel_enc u_enc_red (
    .clk_pixel (clk_pixel),
    .reset     (reset),
    .data      (red_s),
    .blank     (in_blank),
    .ctrl      (2'b00),
    .tmds      (red_core_s)
  );

  tmds_channel_enc u_enc_green (
    .clk_pixel (clk_pixel),
    .reset     (reset),
    .data      (green_s),
    .blank     (in_blank),
    .ctrl      (2'b00),
    .tmds      (green_core_s)
  );

  tmds_channel_enc u_enc_blue (
    .clk_pixel (clk_pixel),
    .reset     (reset),
    .data      (blue_s),
    .blank     (in_blank),
    .ctrl      ({c1_s, c0_s}),
    .tmds      (blue_core_s)
  );

  assign core_s = {red_core_s, green_core_s, blue_core_s};

  if (C_out_reg == 0) begin : g_no_out_reg
    assign {out_red, out_green, out_blue} = core_s;
  end else begin : g_out_reg
    logic [29:0] pipe_r [C_out_reg];

    // Extra output stages, all cleared to the reset word.
    always_ff @(posedge clk_pixel) begin
      if (reset) begin
        for (int i = 0; i < C_out_reg; i++) begin
          pipe_r[i] <= {3{RESET_WORD}};
        end
      end else begin
        pipe_r[0] <= core_s;
        for (int i = 1; i < C_out_reg; i++) begin
          pipe_r[i] <= pipe_r[i-1];
        end
      end
    end

    assign {out_red, out_green, out_blue} = pipe_r[C_out_reg-1];
  end

endmodule

// File: tb/tb_vga2tmds_encoder.sv
// Scoreboard bench for vga2tmds_encoder. Three instances with different
// depth / polarity / output-register settings share sync and blank; a
// reference model pushes expected words per driven pixel and they are
// popped when the matching output emerges.
module tb_vga2tmds_encoder;

  localparam int LAT0 = 3;  // C_out_reg=1
  localparam int LAT3 = 2;  // C_out_reg=0
  localparam int LAT1 = 4;  // C_out_reg=2

  typedef struct packed {
    logic [9:0] r;
    logic [9:0] g;
    logic [9:0] b;
  } exp_t;

  logic       clk_pixel = 1'b0;
  logic       reset;
  logic [7:0] red, green, blue;
  logic [2:0] red3, green3, blue3;
  logic       red1, green1, blue1;
  logic       hsync, vsync, blank;
`ifdef VGA2TMDS_PATTERN_EN
  logic       pattern_en;
  int         pix_model;
`endif
  logic [9:0] o0_r, o0_g, o0_b, o3_r, o3_g, o3_b, o1_r, o1_g, o1_b;

  exp_t sb0[$];
  exp_t sb3[$];
  exp_t sb1[$];
  int   cnt_m [3][3];
  int   total = 0;
  int   bad   = 0;

  always #5 clk_pixel = ~clk_pixel;

  vga2tmds_encoder #(.C_depth(8), .C_hsync_pol(1), .C_vsync_pol(1), .C_out_reg(1)) dut0 (
    .clk_pixel(clk_pixel), .reset(reset),
    .in_red(red), .in_green(green), .in_blue(blue),
    .in_hsync(hsync), .in_vsync(vsync), .in_blank(blank),
`ifdef VGA2TMDS_PATTERN_EN
    .pattern_en(pattern_en),
`endif
    .out_red(o0_r), .out_green(o0_g), .out_blue(o0_b)
  );

  vga2tmds_encoder #(.C_depth(3), .C_hsync_pol(0), .C_vsync_pol(1), .C_out_reg(0)) dut3 (
    .clk_pixel(clk_pixel), .reset(reset),
    .in_red(red3), .in_green(green3), .in_blue(blue3),
    .in_hsync(hsync), .in_vsync(vsync), .in_blank(blank),
`ifdef VGA2TMDS_PATTERN_EN
    .pattern_en(pattern_en),
`endif
    .out_red(o3_r), .out_green(o3_g), .out_blue(o3_b)
  );

  vga2tmds_encoder #(.C_depth(1), .C_hsync_pol(1), .C_vsync_pol(0), .C_out_reg(2)) dut1 (
    .clk_pixel(clk_pixel), .reset(reset),
    .in_red(red1), .in_green(green1), .in_blue(blue1),
    .in_hsync(hsync), .in_vsync(vsync), .in_blank(blank),
`ifdef VGA2TMDS_PATTERN_EN
    .pattern_en(pattern_en),
`endif
    .out_red(o1_r), .out_green(o1_g), .out_blue(o1_b)
  );

  task automatic check(input string tag, input logic [9:0] got, input logic [9:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%h expected=%h at %0t", tag, got, want, $time);
    end
  endtask

  function automatic logic [7:0] expand(input logic [7:0] v, input int depth);
    logic [7:0] e;
    for (int i = 0; i < 8; i++) begin
      e[7-i] = v[depth-1-(i % depth)];
    end
    return e;
  endfunction

  function automatic logic [9:0] ctrl_exp(input logic [1:0] c);
    logic [9:0] w;
    case (c)
      2'b00:   w = 10'h354;
      2'b01:   w = 10'h0AB;
      2'b10:   w = 10'h154;
      default: w = 10'h2AB;
    endcase
    return w;
  endfunction

  task automatic tmds_model(input logic [7:0] d, input int cnt_in,
                            output logic [9:0] w, output int cnt_out);
    int n1d, n1q, n0q;
    bit xn;
    logic [8:0] qm;
    n1d = $countones(d);
    xn  = (n1d > 4) || (n1d == 4 && d[0] == 1'b0);
    qm[0] = d[0];
    for (int i = 1; i < 8; i++) begin
      qm[i] = xn ? ~(qm[i-1] ^ d[i]) : (qm[i-1] ^ d[i]);
    end
    qm[8] = !xn;
    n1q = $countones(qm[7:0]);
    n0q = 8 - n1q;
    if (cnt_in == 0 || n1q == n0q) begin
      w = {~qm[8], qm[8], qm[8] ? qm[7:0] : ~qm[7:0]};
      cnt_out = cnt_in + (qm[8] ? (n1q - n0q) : (n0q - n1q));
    end else if ((cnt_in > 0 && n1q > n0q) || (cnt_in < 0 && n0q > n1q)) begin
      w = {1'b1, qm[8], ~qm[7:0]};
      cnt_out = cnt_in + 2 * int'(qm[8]) + (n0q - n1q);
    end else begin
      w = {1'b0, qm[8], qm[7:0]};
      cnt_out = cnt_in - 2 * int'(!qm[8]) + (n1q - n0q);
    end
  endtask

  task automatic model_inst(input int k, input logic [7:0] r8, input logic [7:0] g8,
                            input logic [7:0] b8, input int hpol, input int vpol,
                            output exp_t e);
    logic c0, c1;
    logic [9:0] w;
    int c;
    c0 = (hpol != 0) ? hsync : ~hsync;
    c1 = (vpol != 0) ? vsync : ~vsync;
    if (blank) begin
      e.r = 10'h354;
      e.g = 10'h354;
      e.b = ctrl_exp({c1, c0});
      for (int ch = 0; ch < 3; ch++) cnt_m[k][ch] = 0;
    end else begin
      tmds_model(r8, cnt_m[k][0], w, c); e.r = w; cnt_m[k][0] = c;
      tmds_model(g8, cnt_m[k][1], w, c); e.g = w; cnt_m[k][1] = c;
      tmds_model(b8, cnt_m[k][2], w, c); e.b = w; cnt_m[k][2] = c;
    end
  endtask

  // Compute and queue the expected words for the inputs currently driven.
  task automatic commit();
    exp_t e;
    logic [7:0] a_r, a_g, a_b, t_r, t_g, t_b, s_r, s_g, s_b;
    a_r = red; a_g = green; a_b = blue;
    t_r = expand({5'b0, red3}, 3); t_g = expand({5'b0, green3}, 3); t_b = expand({5'b0, blue3}, 3);
    s_r = expand({7'b0, red1}, 1); s_g = expand({7'b0, green1}, 1); s_b = expand({7'b0, blue1}, 1);
`ifdef VGA2TMDS_PATTERN_EN
    if (pattern_en && !blank) begin
      int idx;
      idx = (pix_model / 80 > 7) ? 7 : pix_model / 80;
      a_r = (idx & 4) ? 8'hFF : 8'h00;
      a_g = (idx & 2) ? 8'hFF : 8'h00;
      a_b = (idx & 1) ? 8'hFF : 8'h00;
      t_r = a_r; t_g = a_g; t_b = a_b;
      s_r = a_r; s_g = a_g; s_b = a_b;
    end
    if (blank) pix_model = 0;
    else if (pix_model < 2047) pix_model++;
`endif
    model_inst(0, a_r, a_g, a_b, 1, 1, e); sb0.push_back(e);
    model_inst(1, t_r, t_g, t_b, 0, 1, e); sb3.push_back(e);
    model_inst(2, s_r, s_g, s_b, 1, 0, e); sb1.push_back(e);
  endtask

  // Advance one clock and compare every output against the oldest queued entry.
  task automatic tick();
    exp_t e;
    @(posedge clk_pixel);
    #1;
    e = sb0.pop_front();
    check("d8_red", o0_r, e.r); check("d8_green", o0_g, e.g); check("d8_blue", o0_b, e.b);
    e = sb3.pop_front();
    check("d3_red", o3_r, e.r); check("d3_green", o3_g, e.g); check("d3_blue", o3_b, e.b);
    e = sb1.pop_front();
    check("d1_red", o1_r, e.r); check("d1_green", o1_g, e.g); check("d1_blue", o1_b, e.b);
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1;
    blank = 1'b1; hsync = 1'b0; vsync = 1'b0;
    red = 8'h00; green = 8'h00; blue = 8'h00;
    red3 = 3'b000; green3 = 3'b000; blue3 = 3'b000;
    red1 = 1'b0; green1 = 1'b0; blue1 = 1'b0;
    repeat (n) begin
      @(posedge clk_pixel);
      #1;
      check("rst_d8_red", o0_r, 10'h354); check("rst_d8_green", o0_g, 10'h354); check("rst_d8_blue", o0_b, 10'h354);
      check("rst_d3_red", o3_r, 10'h354); check("rst_d3_green", o3_g, 10'h354); check("rst_d3_blue", o3_b, 10'h354);
      check("rst_d1_red", o1_r, 10'h354); check("rst_d1_green", o1_g, 10'h354); check("rst_d1_blue", o1_b, 10'h354);
    end
    reset = 1'b0;
    sb0.delete(); sb3.delete(); sb1.delete();
    for (int k = 0; k < 3; k++) for (int ch = 0; ch < 3; ch++) cnt_m[k][ch] = 0;
`ifdef VGA2TMDS_PATTERN_EN
    pix_model = 0;
`endif
    // Cleared pipeline stages still drain out as the reset word.
    repeat (LAT0 - 1) sb0.push_back({10'h354, 10'h354, 10'h354});
    repeat (LAT3 - 1) sb3.push_back({10'h354, 10'h354, 10'h354});
    repeat (LAT1 - 1) sb1.push_back({10'h354, 10'h354, 10'h354});
    commit();
  endtask

  task automatic ctl(input logic hs, input logic vs, input int n);
    repeat (n) begin
      tick();
      blank = 1'b1; hsync = hs; vsync = vs;
      commit();
    end
  endtask

  task automatic act(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b,
                     input logic [2:0] r3, input logic [2:0] g3, input logic [2:0] b3,
                     input logic r1, input logic g1, input logic b1, input int n);
    repeat (n) begin
      tick();
      blank = 1'b0;
      red = r; green = g; blue = b;
      red3 = r3; green3 = g3; blue3 = b3;
      red1 = r1; green1 = g1; blue1 = b1;
      commit();
    end
  endtask

  task automatic rnd(input int n);
    repeat (n) begin
      tick();
      blank = ($urandom_range(7) == 0);
      hsync = 1'($urandom_range(1)); vsync = 1'($urandom_range(1));
      red = 8'($urandom); green = 8'($urandom); blue = 8'($urandom);
      red3 = 3'($urandom); green3 = 3'($urandom); blue3 = 3'($urandom);
      red1 = 1'($urandom); green1 = 1'($urandom); blue1 = 1'($urandom);
      commit();
    end
  endtask

  initial begin
`ifdef VGA2TMDS_PATTERN_EN
    pattern_en = 1'b0;
    pix_model  = 0;
`endif
    do_reset(3);
    // Control words for each sync combination.
    ctl(1'b1, 1'b0, 4);
    ctl(1'b1, 1'b1, 3);
    ctl(1'b0, 1'b1, 2);
    ctl(1'b0, 1'b0, 2);
    // Black run after blanking: red 0x100, 0x3FF, 0x100.
    act(8'h00, 8'h00, 8'h00, 3'b000, 3'b000, 3'b000, 1'b0, 1'b0, 1'b0, 3);
    ctl(1'b0, 1'b0, 1);
    // Steady 0xB6 green (3-bit 101) and 0xFF (1-bit 1).
    act(8'h10, 8'hB6, 8'hFF, 3'b011, 3'b101, 3'b110, 1'b0, 1'b1, 1'b1, 6);
    ctl(1'b1, 1'b0, 1);
    // Odd-disparity run, blank, then restart from cnt=0.
    act(8'h01, 8'h07, 8'h1F, 3'b001, 3'b111, 3'b100, 1'b1, 1'b0, 1'b1, 5);
    ctl(1'b1, 1'b1, 1);
    act(8'h01, 8'h07, 8'h1F, 3'b001, 3'b111, 3'b100, 1'b1, 1'b0, 1'b1, 3);
    rnd(200);
    // Reset in the middle of active video drops in-flight pixels.
    act(8'hA5, 8'h3C, 8'hF0, 3'b010, 3'b110, 3'b001, 1'b1, 1'b1, 1'b0, 2);
    do_reset(2);
    rnd(40);
`ifdef VGA2TMDS_PATTERN_EN
    ctl(1'b0, 1'b0, 2);
    pattern_en = 1'b1;
    act(8'h5A, 8'h5A, 8'h5A, 3'b010, 3'b010, 3'b010, 1'b1, 1'b0, 1'b1, 170);
    ctl(1'b0, 1'b0, 1);
    pattern_en = 1'b0;
`endif
    ctl(1'b0, 1'b0, 6);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
